sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter sharing the single data SRAM port between instruction fetch (requester 0, IF) and the MEM stage (requester 1, MEM). It grants at most one access per cycle and drives the SRAM port combinationally from the winning requester. It tracks the one outstanding read and steers the next-cycle `sram_rdata` back to its owner with a valid strobe. The block sits between the pipeline stages and the external `data_sram_*` pins.

## Interface
- `PRIO_MODE`, default 0: 0 = round-robin; 1 = MEM fixed priority with IF starvation guard.
- `STARVE_MAX`, default 4: in `PRIO_MODE=1`, the number of consecutive cycles IF may be denied while requesting before it is forced to win. Range 1..15.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF access request; held stable until `if_gnt`.
- `if_wen` in 4: IF byte write enables; 0 = read.
- `if_addr` in 32: IF byte address (physical).
- `if_wdata` in 32: IF write data.
- `if_gnt` out 1: IF request accepted this cycle.
- `if_rvalid` out 1: IF read data valid.
- `if_rdata` out 32: IF read data.
- `mem_req`, `mem_wen`, `mem_addr`, `mem_wdata` in 1/4/32/32: MEM request, same rules as IF.
- `mem_gnt`, `mem_rvalid`, `mem_rdata` out 1/1/32: MEM grant and response, same rules as IF.
- `sram_en` out 1: SRAM port enable.
- `sram_wen` out 4: SRAM byte write enables.
- `sram_addr` out 32: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid one cycle after `sram_en` with `sram_wen`=0.

## Operation
- **Grant (combinational).**
  - Only one requester active: it wins.
  - Both active, `PRIO_MODE=0`: winner = `rr_ptr` (0 = IF, 1 = MEM).
  - Both active, `PRIO_MODE=1`: MEM wins unless `starve_cnt == STARVE_MAX`, in which case IF wins.
  - Neither active: no grant.
- **SRAM port drive.**
  - `sram_en` = any grant.
  - `sram_wen`, `sram_addr`, `sram_wdata` are muxed from the winner.
  - With no grant, these outputs are 0.
- **`rr_ptr` update.** On any contested cycle (both requesting), `rr_ptr` moves to the loser. Uncontested grants do not move it.
- **`starve_cnt` (4 bits).**
  - Increments when IF requests and is denied.
  - Clears when IF is granted or IF does not request.
  - Saturates at `STARVE_MAX`.
- **Read tracking.**
  - On a granted read (`wen`==0), register `rd_pend`=1 and `rd_owner`=winner.
  - The next cycle, `sram_rdata` is routed to the owner's `rdata` and its `rvalid` is pulsed for one cycle.
  - The non-owner's `rdata` reads 0.
- **Writes** complete at grant and produce no response.
- Requesters have no backpressure on responses; `rvalid` must be consumed in the cycle it is asserted.

## Timing
- **Cycle T:** request is seen and the grant plus SRAM drive occur in the same cycle (zero-cycle arbitration).
- **Cycle T+1:** `rvalid` and `rdata` for a read granted in T.
- **Back-to-back:**
  - A new grant is allowed in T+1 while the T response returns, giving one access per cycle sustained.
  - The pending register is overwritten each cycle.
- **Reset values** while `rst_n`=0:
  - `rr_ptr`=0, `starve_cnt`=0, `rd_pend`=0, `rd_owner`=0.
  - Both `gnt`=0, both `rvalid`=0, both `rdata`=0.
  - `sram_en`=0; `sram_wen`, `sram_addr`, `sram_wdata` = 0.
  - Grants are gated by `rst_n` so that no access leaks out during reset.
- **Reset asserted with a read pending:** the response is dropped and no `rvalid` follows after reset release.
- **Simultaneous read and write** from different requesters: only one is granted. The loser holds its request and wins the next contested cycle (`PRIO_MODE=0`).
- **Request deasserted before grant:** illegal. No recovery is required; the bench asserts that this never happens.

## Structure
- Shared package `arb_pkg`:
  - requester ID constants `REQ_IF`=0 and `REQ_MEM`=1;
  - `PRIO_RR`=0 and `PRIO_MEM_FIXED`=1;
  - the request struct {wen[3:0], addr[31:0], wdata[31:0]}.
- One sub-module, `arb_pick2`: the combinational winner select from (req0, req1, rr_ptr, force0, mode). It keeps the grant logic reusable for a later uncached/cached port split.
- The top level holds the `rr_ptr`, `starve_cnt`, and `rd_pend`/`rd_owner` registers, plus the muxes.

## Test plan
- **Reset mid-read:** MEM read to 0x100 granted, then `rst_n` low at T+1 edge minus half a cycle → `mem_rvalid` never asserts, and all outputs are 0 during reset.
- **Single requester:** IF read 0x1FC0_0000 with SRAM returning 0xDEADBEEF → `if_gnt`=1 in T, `if_rvalid`=1 with `if_rdata`=0xDEADBEEF in T+1, `mem_rvalid`=0.
- **Contention, `PRIO_MODE=0`:** both request continuously, each deasserting one cycle after its grant and re-requesting immediately → grants alternate IF, MEM, IF, MEM from reset.
- **Starvation, `PRIO_MODE=1`, `STARVE_MAX=4`:** MEM requests every cycle and IF requests continuously → IF is denied 4 cycles and granted on the 5th; `starve_cnt` returns to 0.
- **Mixed:** MEM write `wen`=4'b0011 to 0x200 with data 0x0000ABCD contends with an IF read → the winner's `sram_wen`/`sram_addr` appear exactly; no `rvalid` follows the write; the IF read response arrives the cycle after IF's grant.
- **Back-to-back reads:** IF granted in T and MEM granted in T+1 → `if_rvalid` at T+1 and `mem_rvalid` at T+2, each carrying its own `sram_rdata` sample.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the SRAM port arbiter slice.
//   REQ_IF / REQ_MEM       : requester identifiers (also the rr_ptr encoding)
//   PRIO_RR / PRIO_MEM_FIXED : arbitration mode selectors
//   req_t                  : one requester's access {wen, addr, wdata}
//   is_read()              : a granted access with no byte enables is a read
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int PRIO_RR        = 0;
  localparam int PRIO_MEM_FIXED = 1;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_read(input req_t r);
    return (r.wen == 4'b0000);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
// Bundles the two requester handshakes and the shared SRAM port.
//   IF  side : if_req/if_wen/if_addr/if_wdata in, if_gnt/if_rvalid/if_rdata out
//   MEM side : mem_* with the same meaning
//   SRAM side: sram_en/sram_wen/sram_addr/sram_wdata out, sram_rdata in
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (pipeline stages plus the SRAM itself)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if;

  logic        if_req;
  logic [3:0]  if_wen;
  logic [31:0] if_addr;
  logic [31:0] if_wdata;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  if_req, if_wen, if_addr, if_wdata,
    output if_gnt, if_rvalid, if_rdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output if_req, if_wen, if_addr, if_wdata,
    input  if_gnt, if_rvalid, if_rdata,
    output mem_req, mem_wen, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2
// Combinational two-way winner select.
//   req0_i / req1_i : active requests (already reset-gated by the caller)
//   rr_ptr_i        : round-robin owner of the next contested cycle
//   force0_i        : fixed-priority override that hands a contest to req0
//   mode_i          : 0 = round-robin, 1 = req1 fixed priority
//   gnt0_o / gnt1_o : one-hot (or zero) grant
// ---------------------------------------------------------------------------
module arb_pick2
  import arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_ptr_i,
  input  logic force0_i,
  input  logic mode_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // A lone requester always wins; only a contest consults mode and pointer.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      if (mode_i) begin
        gnt0_o = force0_i;
      end else begin
        gnt0_o = (rr_ptr_i == REQ_IF);
      end
      gnt1_o = ~gnt0_o;
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares one data SRAM port between instruction fetch and the MEM stage.
// Grant and SRAM drive are combinational in the request cycle; a granted
// read's data is steered back to its owner one cycle later with rvalid.
//   PRIO_MODE  : PRIO_RR or PRIO_MEM_FIXED (MEM wins, IF starvation guard)
//   STARVE_MAX : consecutive IF denials tolerated before IF is forced (1..15)
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshakes and SRAM port (slave modport)
// ---------------------------------------------------------------------------
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int PRIO_MODE  = PRIO_RR,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  sram_port_arbiter_if.slave bus
);

  localparam logic       MODE_FIXED = (PRIO_MODE == PRIO_MEM_FIXED);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       rr_ptr_q, rr_ptr_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  logic if_act, mem_act, gnt_if, gnt_mem, force_if;
  req_t if_r, mem_r, win_r;

  // Gating with rst_n keeps any access from reaching the SRAM while in reset.
  assign if_act  = bus.if_req & rst_n;
  assign mem_act = bus.mem_req & rst_n;

  assign if_r  = '{wen: bus.if_wen,  addr: bus.if_addr,  wdata: bus.if_wdata};
  assign mem_r = '{wen: bus.mem_wen, addr: bus.mem_addr, wdata: bus.mem_wdata};

  assign force_if = MODE_FIXED && (starve_cnt_q == STARVE_LIM);

  arb_pick2 u_pick (
    .req0_i   (if_act),
    .req1_i   (mem_act),
    .rr_ptr_i (rr_ptr_q),
    .force0_i (force_if),
    .mode_i   (MODE_FIXED),
    .gnt0_o   (gnt_if),
    .gnt1_o   (gnt_mem)
  );

  // SRAM port mux: zero when nobody wins so the pins idle cleanly.
  always_comb begin
    win_r = '0;
    if (gnt_if) begin
      win_r = if_r;
    end else if (gnt_mem) begin
      win_r = mem_r;
    end
  end

  assign bus.if_gnt     = gnt_if;
  assign bus.mem_gnt    = gnt_mem;
  assign bus.sram_en    = gnt_if | gnt_mem;
  assign bus.sram_wen   = win_r.wen;
  assign bus.sram_addr  = win_r.addr;
  assign bus.sram_wdata = win_r.wdata;

  // Pointer only moves on a contest, and always to the loser. The starvation
  // counter tracks consecutive denied IF cycles and saturates at the limit.
  // The pending-read register is rewritten every cycle, so back-to-back reads
  // each get their own one-cycle response slot.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = 4'd0;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;

    if (if_act && mem_act) begin
      rr_ptr_d = gnt_if ? REQ_MEM : REQ_IF;
    end

    if (if_act && !gnt_if) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end

    if ((gnt_if || gnt_mem) && is_read(win_r)) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = gnt_mem ? REQ_MEM : REQ_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= REQ_IF;
      starve_cnt_q <= 4'd0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= REQ_IF;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Non-owner (and everyone, when nothing is pending) sees zero read data.
  assign bus.if_rvalid  = rd_pend_q && (rd_owner_q == REQ_IF);
  assign bus.mem_rvalid = rd_pend_q && (rd_owner_q == REQ_MEM);
  assign bus.if_rdata   = bus.if_rvalid  ? bus.sram_rdata : 32'h0;
  assign bus.mem_rdata  = bus.mem_rvalid ? bus.sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter. dut0 runs round-robin and takes the
// vector table plus the reset-mid-read sequence; dut1 runs MEM fixed
// priority (STARVE_MAX=4) and takes the starvation sequence.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sram_port_arbiter_if ifc0 ();
  sram_port_arbiter_if ifc1 ();

  sram_port_arbiter #(.PRIO_MODE(0), .STARVE_MAX(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0.slave)
  );

  sram_port_arbiter #(.PRIO_MODE(1), .STARVE_MAX(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1.slave)
  );

  typedef struct {
    logic        ifReq;
    logic [3:0]  ifWen;
    logic [31:0] ifAddr;
    logic [31:0] ifWdata;
    logic        memReq;
    logic [3:0]  memWen;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] sramRdata;
    logic        expIfGnt;
    logic        expMemGnt;
    logic        expSramEn;
    logic [3:0]  expSramWen;
    logic [31:0] expSramAddr;
    logic [31:0] expSramWdata;
    logic        expIfRvalid;
    logic [31:0] expIfRdata;
    logic        expMemRvalid;
    logic [31:0] expMemRdata;
  } vec_t;

  vec_t vecs [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A request left ungranted must still be present on the next cycle.
  logic wait0If, wait0Mem, wait1If, wait1Mem;
  always @(negedge clk) begin
    if (!rst_n) begin
      wait0If = 1'b0; wait0Mem = 1'b0; wait1If = 1'b0; wait1Mem = 1'b0;
    end else begin
      if (wait0If && !ifc0.if_req) begin
        errors++; $display("[TB] FAIL reqHold dut0.if_req actual=0 required=1");
      end
      if (wait0Mem && !ifc0.mem_req) begin
        errors++; $display("[TB] FAIL reqHold dut0.mem_req actual=0 required=1");
      end
      if (wait1If && !ifc1.if_req) begin
        errors++; $display("[TB] FAIL reqHold dut1.if_req actual=0 required=1");
      end
      if (wait1Mem && !ifc1.mem_req) begin
        errors++; $display("[TB] FAIL reqHold dut1.mem_req actual=0 required=1");
      end
      wait0If  = ifc0.if_req  && !ifc0.if_gnt;
      wait0Mem = ifc0.mem_req && !ifc0.mem_gnt;
      wait1If  = ifc1.if_req  && !ifc1.if_gnt;
      wait1Mem = ifc1.mem_req && !ifc1.mem_gnt;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifc0.if_req     = v.ifReq;
    ifc0.if_wen     = v.ifWen;
    ifc0.if_addr    = v.ifAddr;
    ifc0.if_wdata   = v.ifWdata;
    ifc0.mem_req    = v.memReq;
    ifc0.mem_wen    = v.memWen;
    ifc0.mem_addr   = v.memAddr;
    ifc0.mem_wdata  = v.memWdata;
    ifc0.sram_rdata = v.sramRdata;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.if_gnt", i),     32'(ifc0.if_gnt),     32'(v.expIfGnt));
    checkOutput($sformatf("v%0d.mem_gnt", i),    32'(ifc0.mem_gnt),    32'(v.expMemGnt));
    checkOutput($sformatf("v%0d.sram_en", i),    32'(ifc0.sram_en),    32'(v.expSramEn));
    checkOutput($sformatf("v%0d.sram_wen", i),   32'(ifc0.sram_wen),   32'(v.expSramWen));
    checkOutput($sformatf("v%0d.sram_addr", i),  ifc0.sram_addr,       v.expSramAddr);
    checkOutput($sformatf("v%0d.sram_wdata", i), ifc0.sram_wdata,      v.expSramWdata);
    checkOutput($sformatf("v%0d.if_rvalid", i),  32'(ifc0.if_rvalid),  32'(v.expIfRvalid));
    checkOutput($sformatf("v%0d.if_rdata", i),   ifc0.if_rdata,        v.expIfRdata);
    checkOutput($sformatf("v%0d.mem_rvalid", i), 32'(ifc0.mem_rvalid), 32'(v.expMemRvalid));
    checkOutput($sformatf("v%0d.mem_rdata", i),  ifc0.mem_rdata,       v.expMemRdata);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".if_gnt"},     32'(ifc0.if_gnt),     32'h0);
    checkOutput({tag, ".mem_gnt"},    32'(ifc0.mem_gnt),    32'h0);
    checkOutput({tag, ".sram_en"},    32'(ifc0.sram_en),    32'h0);
    checkOutput({tag, ".sram_wen"},   32'(ifc0.sram_wen),   32'h0);
    checkOutput({tag, ".sram_addr"},  ifc0.sram_addr,       32'h0);
    checkOutput({tag, ".sram_wdata"}, ifc0.sram_wdata,      32'h0);
    checkOutput({tag, ".if_rvalid"},  32'(ifc0.if_rvalid),  32'h0);
    checkOutput({tag, ".if_rdata"},   ifc0.if_rdata,        32'h0);
    checkOutput({tag, ".mem_rvalid"}, 32'(ifc0.mem_rvalid), 32'h0);
    checkOutput({tag, ".mem_rdata"},  ifc0.mem_rdata,       32'h0);
  endtask

  task automatic idleIfc1();
    ifc1.if_req = 1'b0; ifc1.if_wen = 4'h0; ifc1.if_addr = 32'h0; ifc1.if_wdata = 32'h0;
    ifc1.mem_req = 1'b0; ifc1.mem_wen = 4'h0; ifc1.mem_addr = 32'h0; ifc1.mem_wdata = 32'h0;
    ifc1.sram_rdata = 32'h0;
  endtask

  // Main sequence: reset state, vector table, starvation, reset mid-read.
  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
             1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};

    //            ifReq wen   addr          wdata         memReq wen  addr      wdata         sramRdata       ifG   memG  en    swen  saddr         swdata        ifRv  ifRd          memRv memRd
    vecs[0]  = '{1'b1, 4'h0, 32'h1FC00000, 32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 32'h1FC00000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        32'hDEADBEEF,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        32'h12345678,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 4'h0, 32'h10,       32'h0,        1'b1, 4'h0, 32'h20,  32'h0,        32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 32'h10,       32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h14,       32'h0,        1'b1, 4'h0, 32'h20,  32'h0,        32'h11111111,   1'b0, 1'b1, 1'b1, 4'h0, 32'h20,       32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'h0, 32'h14,       32'h0,        1'b1, 4'h0, 32'h24,  32'h0,        32'h22222222,   1'b1, 1'b0, 1'b1, 4'h0, 32'h14,       32'h0,        1'b0, 32'h0,        1'b1, 32'h22222222};
    vecs[6]  = '{1'b1, 4'h0, 32'h18,       32'h0,        1'b1, 4'h0, 32'h24,  32'h0,        32'h33333333,   1'b0, 1'b1, 1'b1, 4'h0, 32'h24,       32'h0,        1'b1, 32'h33333333, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 4'h0, 32'h18,       32'h0,        1'b1, 4'h3, 32'h200, 32'h0000ABCD, 32'h44444444,   1'b1, 1'b0, 1'b1, 4'h0, 32'h18,       32'h0,        1'b0, 32'h0,        1'b1, 32'h44444444};
    vecs[8]  = '{1'b1, 4'h0, 32'h1C,       32'h0,        1'b1, 4'h3, 32'h200, 32'h0000ABCD, 32'h55555555,   1'b0, 1'b1, 1'b1, 4'h3, 32'h200,      32'h0000ABCD, 1'b1, 32'h55555555, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 4'h0, 32'h1C,       32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        32'h66666666,   1'b1, 1'b0, 1'b1, 4'h0, 32'h1C,       32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        32'h77777777,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h77777777, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 4'h0, 32'h34,       32'h0,        1'b1, 4'h0, 32'h38,  32'h0,        32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 32'h34,       32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 4'h0, 32'h38,  32'h0,        32'h88888888,   1'b0, 1'b1, 1'b1, 4'h0, 32'h38,       32'h0,        1'b1, 32'h88888888, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 4'h0, 32'h3C,       32'hCAFEF00D, 1'b1, 4'h0, 32'h40,  32'h0,        32'h99999999,   1'b0, 1'b1, 1'b1, 4'h0, 32'h40,       32'h0,        1'b0, 32'h0,        1'b1, 32'h99999999};
    vecs[14] = '{1'b1, 4'h0, 32'h3C,       32'hCAFEF00D, 1'b0, 4'h0, 32'h0,   32'h0,        32'hAAAAAAAA,   1'b1, 1'b0, 1'b1, 4'h0, 32'h3C,       32'hCAFEF00D, 1'b0, 32'h0,        1'b1, 32'hAAAAAAAA};
    vecs[15] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        32'hBBBBBBBB,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'hBBBBBBBB, 1'b0, 32'h0};

    // Reset with both requesters active: nothing may leak out.
    rst_n = 1'b0;
    idleIfc1();
    applyStimulus(idle);
    ifc0.if_req = 1'b1; ifc0.if_addr = 32'h1234; ifc0.if_wdata = 32'h5678; ifc0.if_wen = 4'hF;
    ifc0.mem_req = 1'b1; ifc0.mem_addr = 32'h9ABC;
    ifc0.sram_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");

    @(posedge clk); #1;
    applyStimulus(idle);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      @(posedge clk); #1;
    end
    applyStimulus(idle);

    // Fixed priority: MEM wins four contests, IF is forced on the fifth.
    for (int c = 0; c < 5; c++) begin
      ifc1.if_req = 1'b1; ifc1.if_addr = 32'h50;
      ifc1.mem_req = 1'b1; ifc1.mem_addr = 32'h60 + 32'(4 * c);
      @(negedge clk);
      checkOutput($sformatf("starve%0d.if_gnt", c),  32'(ifc1.if_gnt),  (c == 4) ? 32'h1 : 32'h0);
      checkOutput($sformatf("starve%0d.mem_gnt", c), 32'(ifc1.mem_gnt), (c == 4) ? 32'h0 : 32'h1);
      checkOutput($sformatf("starve%0d.cnt", c),     32'(dut1.starve_cnt_q), 32'(c));
      @(posedge clk); #1;
    end
    ifc1.if_req = 1'b0;
    ifc1.mem_req = 1'b1; ifc1.mem_addr = 32'h70;
    ifc1.sram_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    checkOutput("starve5.mem_gnt",   32'(ifc1.mem_gnt),      32'h1);
    checkOutput("starve5.sram_addr", ifc1.sram_addr,          32'h70);
    checkOutput("starve5.cnt",       32'(dut1.starve_cnt_q), 32'h0);
    checkOutput("starve5.if_rvalid", 32'(ifc1.if_rvalid),    32'h1);
    checkOutput("starve5.if_rdata",  ifc1.if_rdata,           32'h5A5A5A5A);
    @(posedge clk); #1;
    idleIfc1();

    // Reset lands half a cycle after a MEM read grant: its response is lost.
    ifc0.mem_req = 1'b1; ifc0.mem_wen = 4'h0; ifc0.mem_addr = 32'h100;
    ifc0.sram_rdata = 32'hC0FFEE00;
    @(negedge clk);
    checkOutput("rstRd.mem_gnt",   32'(ifc0.mem_gnt), 32'h1);
    checkOutput("rstRd.sram_addr", ifc0.sram_addr,    32'h100);
    rst_n = 1'b0;
    #1;
    checkAllZero("rstRd.inReset");
    @(posedge clk); #1;
    checkAllZero("rstRd.afterEdge");
    applyStimulus(idle);
    ifc0.sram_rdata = 32'hC0FFEE00;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstRd.post%0d.mem_rvalid", k), 32'(ifc0.mem_rvalid), 32'h0);
      checkOutput($sformatf("rstRd.post%0d.mem_rdata", k),  ifc0.mem_rdata,       32'h0);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
